// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 Hz raster constants, FSM state type and colour widths
// shared by the vga_timing block and its interface.
package vga_timing_pkg;

  localparam int DEF_H_VISIBLE  = 640;
  localparam int DEF_H_FRONT    = 16;
  localparam int DEF_H_SYNC     = 96;
  localparam int DEF_H_BACK     = 48;
  localparam int DEF_V_VISIBLE  = 480;
  localparam int DEF_V_FRONT    = 10;
  localparam int DEF_V_SYNC     = 2;
  localparam int DEF_V_BACK     = 33;
  localparam int DEF_LOCK_DELAY = 1023;

  localparam int H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  localparam int RGB_W = 12;
  localparam int CH_W  = 4;
  localparam int XY_W  = 10;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    SETTLE,
    RUN
  } state_t;

endpackage

// File: rtl/vga_timing_if.sv
// Raster-side signal bundle: lock/pixel in, counters, syncs and colour out.
interface vga_timing_if;
  import vga_timing_pkg::*;

  logic              locked;
  logic [RGB_W-1:0]  pixel;
  logic [XY_W-1:0]   x;
  logic [XY_W-1:0]   y;
  logic              frame;
  logic              ready;
  logic              hs;
  logic              vs;
  logic              de;
  logic [CH_W-1:0]   r;
  logic [CH_W-1:0]   g;
  logic [CH_W-1:0]   b;

  modport master (
    input  locked, pixel,
    output x, y, frame, ready, hs, vs, de, r, g, b
  );

  modport slave (
    output locked, pixel,
    input  x, y, frame, ready, hs, vs, de, r, g, b
  );

endinterface

// File: rtl/vga_timing_lock_sync.sv
// PLL lock synchroniser and settle timer; ready means the raster may run.
//   state     | meaning
//   WAIT_LOCK | synchronised lock low, raster held
//   SETTLE    | lock high, counting LOCK_DELAY clocks of stable lock
//   RUN       | raster counters running
module vga_timing_lock_sync
  import vga_timing_pkg::*;
#(
  parameter int LOCK_DELAY = DEF_LOCK_DELAY
) (
  input  logic clkin,
  input  logic rst,
  input  logic locked,
  output logic ready,
  output logic run_next
);

  localparam int CW = (LOCK_DELAY < 2) ? 1 : $clog2(LOCK_DELAY);
  localparam logic [CW-1:0] CNT_END = CW'(LOCK_DELAY - 1);

  if (LOCK_DELAY < 1) begin : g_bad_delay
    $error("LOCK_DELAY must be at least 1");
  end

  logic [1:0]    sync;
  logic          lk;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clkin) begin
    if (rst) begin
      sync  <= 2'b00;
      state <= WAIT_LOCK;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], locked};
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  assign lk = sync[1];

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      WAIT_LOCK: begin
        cnt_nx = '0;
        if (lk) state_nx = SETTLE;
      end
      SETTLE: begin
        if (!lk) begin
          state_nx = WAIT_LOCK;
          cnt_nx   = '0;
        end else if (cnt == CNT_END) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lk) state_nx = WAIT_LOCK;
      end
      default: state_nx = WAIT_LOCK;
    endcase
  end

  assign ready    = (state == RUN);
  // Raster registers look ahead so they blank on the same edge that leaves RUN.
  assign run_next = (state_nx == RUN);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing generator: x/y one clock ahead of registered hs/vs/de/rgb.
// Define VGA_TESTPAT_EN to replace the pixel input with x-derived colour bars.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = DEF_H_VISIBLE,
  parameter int H_FRONT    = DEF_H_FRONT,
  parameter int H_SYNC     = DEF_H_SYNC,
  parameter int H_BACK     = DEF_H_BACK,
  parameter int V_VISIBLE  = DEF_V_VISIBLE,
  parameter int V_FRONT    = DEF_V_FRONT,
  parameter int V_SYNC     = DEF_V_SYNC,
  parameter int V_BACK     = DEF_V_BACK,
  parameter bit SYNC_POL   = 1'b0,
  parameter int LOCK_DELAY = DEF_LOCK_DELAY
) (
  input  logic         clkin,
  input  logic         rst,
  vga_timing_if.master bus
);

  localparam int H_SUM = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_SUM = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  if (H_SUM > (1 << XY_W) || V_SUM > (1 << XY_W)) begin : g_bad_timing
    $error("raster totals do not fit the 10-bit counters");
  end

  localparam logic [XY_W-1:0] H_LAST   = XY_W'(H_SUM - 1);
  localparam logic [XY_W-1:0] V_LAST   = XY_W'(V_SUM - 1);
  localparam logic [XY_W-1:0] H_VIS    = XY_W'(H_VISIBLE);
  localparam logic [XY_W-1:0] V_VIS    = XY_W'(V_VISIBLE);
  localparam logic [XY_W-1:0] HS_FIRST = XY_W'(H_VISIBLE + H_FRONT);
  localparam logic [XY_W-1:0] HS_LAST  = XY_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [XY_W-1:0] VS_FIRST = XY_W'(V_VISIBLE + V_FRONT);
  localparam logic [XY_W-1:0] VS_LAST  = XY_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic             ready, run_next, adv;
  logic [XY_W-1:0]  x_cnt, y_cnt;
  logic             de0, hs0, vs0;
  logic [RGB_W-1:0] colour;
  logic             hs_q, vs_q, de_q;
  logic [RGB_W-1:0] rgb_q;

  vga_timing_lock_sync #(.LOCK_DELAY(LOCK_DELAY)) u_lock_sync (
    .clkin    (clkin),
    .rst      (rst),
    .locked   (bus.locked),
    .ready    (ready),
    .run_next (run_next)
  );

  // Counters advance only between two RUN cycles; the first RUN cycle shows 0,0.
  assign adv = ready & run_next;

  always_ff @(posedge clkin) begin
    if (rst || !adv) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (x_cnt == H_LAST) begin
      x_cnt <= '0;
      y_cnt <= (y_cnt == V_LAST) ? '0 : y_cnt + 1'b1;
    end else begin
      x_cnt <= x_cnt + 1'b1;
    end
  end

  assign de0 = (x_cnt < H_VIS) && (y_cnt < V_VIS);
  assign hs0 = (x_cnt >= HS_FIRST) && (x_cnt <= HS_LAST);
  assign vs0 = (y_cnt >= VS_FIRST) && (y_cnt <= VS_LAST);

`ifdef VGA_TESTPAT_EN
  logic [2:0] bar;
  assign bar    = x_cnt[9:7];
  assign colour = {{CH_W{bar[2]}}, {CH_W{bar[1]}}, {CH_W{bar[0]}}};
`else
  assign colour = bus.pixel;
`endif

  always_ff @(posedge clkin) begin
    if (rst || !adv) begin
      hs_q  <= ~SYNC_POL;
      vs_q  <= ~SYNC_POL;
      de_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      hs_q  <= hs0 ? SYNC_POL : ~SYNC_POL;
      vs_q  <= vs0 ? SYNC_POL : ~SYNC_POL;
      de_q  <= de0;
      rgb_q <= de0 ? colour : '0;
    end
  end

  assign bus.x     = x_cnt;
  assign bus.y     = y_cnt;
  assign bus.frame = ready && (x_cnt == '0) && (y_cnt == '0);
  assign bus.ready = ready;
  assign bus.hs    = hs_q;
  assign bus.vs    = vs_q;
  assign bus.de    = de_q;
  assign bus.r     = rgb_q[11:8];
  assign bus.g     = rgb_q[7:4];
  assign bus.b     = rgb_q[3:0];

endmodule

// File: tb/tb_vga_timing.sv
// Scoreboard bench for vga_timing: the driver queues expected samples keyed by
// clock number, a negedge monitor pops and compares them (short 19-line frame).
module tb_vga_timing;

`ifdef VGA_TESTPAT_EN
  localparam bit TP = 1'b1;
`else
  localparam bit TP = 1'b0;
`endif

  localparam int R  = 14;           // first RUN cycle after reset release
  localparam int L  = R + 16305;    // cycle after which lock is restored
  localparam int R2 = L + 11;       // first RUN cycle after relock

  localparam logic [36:0] M_RDY = 37'h1 << 36;
  localparam logic [36:0] M_FRM = 37'h1 << 35;
  localparam logic [36:0] M_HS  = 37'h1 << 34;
  localparam logic [36:0] M_VS  = 37'h1 << 33;
  localparam logic [36:0] M_DE  = 37'h1 << 32;
  localparam logic [36:0] M_RGB = 37'hFFF << 20;
  localparam logic [36:0] M_XY  = 37'hF_FFFF;
  localparam logic [36:0] M_ALL = {37{1'b1}};

  localparam int K_VEC = 0, K_HSRUN = 1, K_VSRUN = 2, K_GAP = 3, K_DEFRM = 4;

  typedef struct {
    int          cyc;
    int          kind;
    logic [36:0] msk;
    logic [36:0] ex;
    string       name;
  } item_t;

  logic  clkin;
  logic  rst;
  int    cyc;
  int    checks;
  int    errors;
  item_t q[$];

  vga_timing_if bus();

  vga_timing #(
    .V_VISIBLE  (12),
    .V_FRONT    (2),
    .V_SYNC     (2),
    .V_BACK     (3),
    .LOCK_DELAY (8)
  ) dut (
    .clkin (clkin),
    .rst   (rst),
    .bus   (bus.master)
  );

  initial begin
    clkin = 1'b0;
    forever #20 clkin = ~clkin;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clkin);
      cyc++;
    end
  end

  function automatic logic [36:0] mk(bit rdy, bit frm, bit hs, bit vs, bit de,
                                     logic [11:0] rgb, logic [9:0] xv, logic [9:0] yv);
    return {rdy, frm, hs, vs, de, rgb, xv, yv};
  endfunction

  task automatic push(int at, string nm, int kind, logic [36:0] msk, logic [36:0] ex);
    item_t it;
    int    i;
    it.cyc  = at;
    it.kind = kind;
    it.msk  = msk;
    it.ex   = ex;
    it.name = nm;
    i = q.size();
    while (i > 0 && q[i-1].cyc > at) i--;
    q.insert(i, it);
  endtask

  task automatic stat(int at, string nm, int kind, int val);
    push(at, nm, kind, M_ALL, 37'(val));
  endtask

  task automatic wait_cyc(int c);
    while (cyc < c) begin
      @(posedge clkin);
      #1;
    end
  endtask

  // Monitor: running statistics plus scoreboard comparison at each negedge.
  initial begin
    logic [36:0] obs;
    item_t       it;
    int          hs_cur, hs_run, vs_cur, vs_run;
    int          frame_last, frame_gap, de_cnt, frame_de, act;
    checks = 0; errors = 0;
    hs_cur = 0; hs_run = 0; vs_cur = 0; vs_run = 0;
    frame_last = 0; frame_gap = 0; de_cnt = 0; frame_de = 0;
    forever begin
      @(negedge clkin);
      obs = {bus.ready, bus.frame, bus.hs, bus.vs, bus.de, bus.r, bus.g, bus.b, bus.x, bus.y};
      if (bus.hs === 1'b0) hs_cur++;
      else begin
        if (hs_cur != 0) hs_run = hs_cur;
        hs_cur = 0;
      end
      if (bus.vs === 1'b0) vs_cur++;
      else begin
        if (vs_cur != 0) vs_run = vs_cur;
        vs_cur = 0;
      end
      if (bus.frame === 1'b1) begin
        frame_gap  = cyc - frame_last;
        frame_last = cyc;
        frame_de   = de_cnt;
        de_cnt     = (bus.de === 1'b1) ? 1 : 0;
      end else if (bus.de === 1'b1) begin
        de_cnt++;
      end
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        it = q.pop_front();
        checks++;
        if (it.cyc < cyc) begin
          errors++;
          $display("FAIL %s: sample for cycle %0d not taken (now %0d)", it.name, it.cyc, cyc);
        end else if (it.kind == K_VEC) begin
          if ((obs & it.msk) !== (it.ex & it.msk)) begin
            errors++;
            $display("FAIL %s @%0d: got %h want %h (mask %h) [rdy,frm,hs,vs,de,rgb,x,y]",
                     it.name, cyc, obs & it.msk, it.ex & it.msk, it.msk);
          end
        end else begin
          case (it.kind)
            K_HSRUN: act = hs_run;
            K_VSRUN: act = vs_run;
            K_GAP:   act = frame_gap;
            default: act = frame_de;
          endcase
          if (37'(act) !== it.ex) begin
            errors++;
            $display("FAIL %s @%0d: got %0d want %0d", it.name, cyc, act, it.ex);
          end
        end
      end
    end
  end

  initial begin
    #(40 * 40000);
    $display("FAIL watchdog: simulation did not finish within 40000 clocks");
    $fatal(1, "watchdog expired");
  end

  // Driver
  initial begin
    rst        = 1'b1;
    bus.locked = 1'b1;
    bus.pixel  = 12'h000;

    push(3,  "reset",     K_VEC, M_ALL, mk(0, 0, 1, 1, 0, 12'h000, 0, 0));
    push(13, "pre_run",   K_VEC, M_RDY | M_HS | M_VS | M_DE | M_RGB, mk(0, 0, 1, 1, 0, 12'h000, 0, 0));
    push(R,  "run_start", K_VEC, M_ALL, mk(1, 1, 1, 1, 0, 12'h000, 0, 0));
    wait_cyc(3);
    rst = 1'b0;

    wait_cyc(R);
    push(R + 1,     "de_x0",     K_VEC, M_FRM | M_DE | M_RGB | M_XY, mk(0, 0, 0, 0, 1, 12'h000, 1, 0));
    push(R + 640,   "de_x639",   K_VEC, M_DE, mk(0, 0, 0, 0, 1, 0, 0, 0));
    push(R + 641,   "de_x640",   K_VEC, M_DE, mk(0, 0, 0, 0, 0, 0, 0, 0));
    push(R + 656,   "hs_pre",    K_VEC, M_HS | M_XY, mk(0, 0, 1, 0, 0, 0, 656, 0));
    push(R + 657,   "hs_fall",   K_VEC, M_HS, mk(0, 0, 0, 0, 0, 0, 0, 0));
    push(R + 752,   "hs_last",   K_VEC, M_HS, mk(0, 0, 0, 0, 0, 0, 0, 0));
    push(R + 753,   "hs_rise",   K_VEC, M_HS, mk(0, 0, 1, 0, 0, 0, 0, 0));
    stat(R + 753,   "hs_width",  K_HSRUN, 96);
    push(R + 800,   "line_wrap", K_VEC, M_FRM | M_XY, mk(0, 0, 0, 0, 0, 0, 0, 1));
    push(R + 9440,  "de_y11",    K_VEC, M_DE, mk(0, 0, 0, 0, 1, 0, 0, 0));
    push(R + 9601,  "de_y12",    K_VEC, M_DE, mk(0, 0, 0, 0, 0, 0, 0, 0));
    push(R + 11200, "vs_pre",    K_VEC, M_VS, mk(0, 0, 0, 1, 0, 0, 0, 0));
    push(R + 11201, "vs_fall",   K_VEC, M_VS, mk(0, 0, 0, 0, 0, 0, 0, 0));
    push(R + 12800, "vs_last",   K_VEC, M_VS, mk(0, 0, 0, 0, 0, 0, 0, 0));
    push(R + 12801, "vs_rise",   K_VEC, M_VS, mk(0, 0, 0, 1, 0, 0, 0, 0));
    stat(R + 12801, "vs_width",  K_VSRUN, 1600);
    push(R + 15199, "frame_end", K_VEC, M_FRM | M_XY, mk(0, 0, 0, 0, 0, 0, 799, 18));
    push(R + 15200, "frame2",    K_VEC, M_FRM | M_XY, mk(0, 1, 0, 0, 0, 0, 0, 0));
    stat(R + 15200, "frame_gap", K_GAP, 15200);
    stat(R + 15200, "de_per_frame", K_DEFRM, 7680);

    // pixel is sampled on the edge that ends the cycle presenting its x/y
    wait_cyc(R + 5605);
    push(R + 5606, "pix_abc",   K_VEC, M_DE | M_RGB, mk(0, 0, 0, 0, 1, TP ? 12'h000 : 12'hABC, 0, 0));
    push(R + 5607, "pix_after", K_VEC, M_DE | M_RGB, mk(0, 0, 0, 0, 1, 12'h000, 0, 0));
    bus.pixel = 12'hABC;
    wait_cyc(R + 5606);
    bus.pixel = 12'h000;

    wait_cyc(R + 6239);
    push(R + 6240, "pix_x639", K_VEC, M_DE | M_RGB, mk(0, 0, 0, 0, 1, TP ? 12'hF00 : 12'hFFF, 0, 0));
    push(R + 6241, "pix_x640", K_VEC, M_DE | M_RGB, mk(0, 0, 0, 0, 0, 12'h000, 0, 0));
    push(R + 6301, "pix_x700", K_VEC, M_DE | M_RGB, mk(0, 0, 0, 0, 0, 12'h000, 0, 0));
    bus.pixel = 12'hFFF;
    wait_cyc(R + 6301);
    bus.pixel = 12'h000;

    // line y=10: bars 0 (x=0), 1 (x=130) and 4 (x=600, range 512..639)
    wait_cyc(R + 8000);
    push(R + 8001, "y10_x0",   K_VEC, M_DE | M_RGB, mk(0, 0, 0, 0, 1, TP ? 12'h000 : 12'h5A3, 0, 0));
    push(R + 8131, "y10_x130", K_VEC, M_DE | M_RGB, mk(0, 0, 0, 0, 1, TP ? 12'h00F : 12'h5A3, 0, 0));
    push(R + 8601, "y10_x600", K_VEC, M_DE | M_RGB, mk(0, 0, 0, 0, 1, TP ? 12'hF00 : 12'h5A3, 0, 0));
    bus.pixel = 12'h5A3;
    wait_cyc(R + 8601);
    bus.pixel = 12'h000;

    // lock lost while x=300, y=1 of the second frame
    wait_cyc(R + 16300);
    push(R + 16302, "lk_hold", K_VEC, M_RDY | M_DE | M_RGB, mk(1, 0, 0, 0, 1, TP ? 12'h0F0 : 12'hFFF, 0, 0));
    push(R + 16303, "lk_lost", K_VEC, M_ALL, mk(0, 0, 1, 1, 0, 12'h000, 0, 0));
    bus.locked = 1'b0;
    bus.pixel  = 12'hFFF;

    wait_cyc(L);
    push(L + 5,  "wait_blank", K_VEC, M_ALL, mk(0, 0, 1, 1, 0, 12'h000, 0, 0));
    push(L + 10, "settling",   K_VEC, M_RDY, mk(0, 0, 0, 0, 0, 0, 0, 0));
    push(L + 11, "relock",     K_VEC, M_ALL, mk(1, 1, 1, 1, 0, 12'h000, 0, 0));
    bus.locked = 1'b1;

    // reset pulse at x=400, y=2
    wait_cyc(R2 + 2000);
    push(R2 + 2000, "pre_rst", K_VEC, M_RDY | M_HS | M_DE | M_RGB | M_XY,
         mk(1, 0, 1, 0, 1, TP ? 12'h0FF : 12'hFFF, 400, 2));
    push(R2 + 2001, "rst_mid",     K_VEC, M_ALL, mk(0, 0, 1, 1, 0, 12'h000, 0, 0));
    push(R2 + 2011, "rst_settle",  K_VEC, M_RDY, mk(0, 0, 0, 0, 0, 0, 0, 0));
    push(R2 + 2012, "rst_restart", K_VEC, M_ALL, mk(1, 1, 1, 1, 0, 12'h000, 0, 0));
    rst = 1'b1;
    wait_cyc(R2 + 2001);
    rst = 1'b0;

    wait_cyc(R2 + 2015);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
